// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests, with a starvation counter
// that forces a fetch grant after STARVE_MAX data grants made while fetch waits.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic             d_req,
    input  logic             grant_strobe,
    output logic             winner,
    output logic [CNT_W-1:0] starve_cnt
);

    owner_t win;
    logic   starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        win = OWN_I;
        if (d_req && !(i_req && starved)) begin
            win = OWN_D;
        end
    end

    assign winner = win;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_strobe) begin
            if (win == OWN_I) begin
                starve_cnt <= '0;
            end else if (i_req && !starved) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data ports:
// one access at a time, fixed read latency, one-cycle ready pulse per request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LAT        = 1,
    parameter int STARVE_MAX = 4
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state;
    owner_t            owner;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  starve_cnt_unused;
    logic [DATA_W-1:0] i_hold;
    logic [DATA_W-1:0] d_hold;
    logic              winner;
    logic              grant;
    logic              done;
    logic              rd_done;

    assign grant = (state == IDLE) && (i_req || d_req);

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .d_req       (d_req),
        .grant_strobe(grant),
        .winner      (winner),
        .starve_cnt  (starve_cnt_unused)
    );

    // Writes reuse WAIT with a zero count as their single completion cycle.
    assign done    = (state == WAIT) && (wait_cnt == '0);
    assign rd_done = done && !mem_we;
    assign i_ready = done && (owner == OWN_I);
    assign d_ready = done && (owner == OWN_D);
    assign i_rdata = (rd_done && owner == OWN_I) ? mem_rdata : i_hold;
    assign d_rdata = (rd_done && owner == OWN_D) ? mem_rdata : d_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_I;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            i_hold    <= '0;
            d_hold    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner  <= owner_t'(winner);
                        mem_en <= 1'b1;
                        state  <= ISSUE;
                        if (owner_t'(winner) == OWN_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    wait_cnt <= mem_we ? '0 : CNT_W'(LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= IDLE;
                        if (!mem_we) begin
                            if (owner == OWN_I) begin
                                i_hold <= mem_rdata;
                            end else begin
                                d_hold <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-ported unified memory between the processor's instruction-fetch port (read-only) and data port (read/write).
- Sits between the riscv core and one shared memory, replacing separate imem/dmem.
- Issues one access at a time, models the memory's fixed read latency and returns data with a one-cycle ready pulse per requester.
- Requesters treat ready-low as a stall.
- Data port has priority; bounded starvation protection guarantees forward progress for instruction fetch.

Parameters:
- DATA_W, 32, data width of all data buses
- ADDR_W, 32, address width of all address buses
- LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive data grants allowed while i_req is pending before fetch is forced; legal range 1..15

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, held with i_addr stable until i_ready
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch data
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data
- d_ready  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access strobe, high exactly one cycle per access
- mem_we  out  1  memory write enable, valid when mem_en is high
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after the mem_en cycle

Behaviour:
- Reset values: state IDLE; mem_en, mem_we, i_ready, d_ready = 0; mem_addr, mem_wdata = 0; held i_rdata/d_rdata registers = 0; starvation counter = 0; grant owner = I.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, no request: stay in IDLE.
- IDLE, one or both requests: pick a winner, latch its addr/we/wdata into the mem_* registers, record the owner, go to ISSUE.
- Arbitration when both request: D wins unless starve_cnt == STARVE_MAX, in which case I wins.
- starve_cnt: +1 on each D grant made while i_req is high; cleared on every I grant; saturates at STARVE_MAX.
- ISSUE: mem_en = 1 for exactly this cycle (cycle k).
  - Write: next state is a one-cycle completion; d_ready pulses at cycle k+1; the memory write is committed at k.
  - Read: load wait counter with LAT-1 and go to WAIT.
- WAIT: decrement the counter; the cycle where counter == 0 is cycle k+LAT.
  - In that cycle the owner's ready = 1 and x_rdata = mem_rdata combinationally.
  - mem_rdata is also captured into the owner's held register.
- Completion cycle transitions to IDLE. Outside the completion cycle, x_rdata shows the held register, i.e. the last completed read for that port.
- Timing:
  - Read: request sampled at cycle t (IDLE), mem_en at t+1, ready at t+1+LAT, next sample at t+2+LAT.
  - Write: ready at t+2, next sample at t+3.
- Requester rule: the cycle after ready, the request lines are re-sampled as a new request. A requester that still holds req high with the same address gets a second access. The pipeline must advance or drop req on ready.
- Fetch never writes: mem_we = 0 whenever the owner is I.
- Request lines are sampled only in IDLE. Changes during ISSUE/WAIT are ignored; the latched copy is used.
- Only one ready may be high per cycle. i_ready and d_ready are never simultaneous.
- Reset asserted mid-access: return to IDLE next edge and drop the in-flight access; no ready pulse is generated. A write already strobed stays committed.
- Addresses pass through unmodified; no alignment checking.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT}
  - owner enum {OWN_I, OWN_D}
  - CNT_W = 4 localparam for the wait and starvation counters
- One sub-module, mem_arb_pick, is natural: the combinational winner selection plus the registered starvation counter. Inputs i_req, d_req, grant_strobe. Outputs winner, starve_cnt.
- FSM, latency counter and data steering stay in mem_arbiter.

Test Plan:
- Single fetch, LAT=1: i_req=1, i_addr=0x40 at cycle 0, memory returns 0x00500113.
  - Expect mem_en at cycle 1 with mem_addr=0x40, mem_we=0.
  - Expect i_ready=1 and i_rdata=0x00500113 at cycle 2.
  - Expect i_rdata to hold that value afterwards.
- Data write: d_req=1, d_we=1, d_addr=0x64, d_wdata=0x19 at cycle 0.
  - Expect mem_en=1, mem_we=1, mem_addr=0x64, mem_wdata=0x19 at cycle 1.
  - Expect d_ready=1 at cycle 2 and i_ready=0 throughout.
- Simultaneous requests: i_req and d_req (read of 0x80) both high at cycle 0, LAT=2.
  - D served first: mem_en at 1, d_ready at 3.
  - I re-sampled at 4: mem_en at 5, i_ready at 7.
- Starvation, STARVE_MAX=2: i_req held high while d_req issues back-to-back reads.
  - Grants are D, D, then I, then D.
  - starve_cnt reads 0, 1, 2, then 0 after the I grant.
- Reset in WAIT, LAT=3: data read issued, reset=1 for one cycle during WAIT.
  - No d_ready pulse occurs.
  - State returns to IDLE; d_rdata = 0; mem_en = 0.
  - A subsequent fetch completes normally with LAT+2 timing.
- LAT sweep 1/4/15 with random interleaved requests against a scoreboard memory model:
  - Every request gets exactly one ready.
  - Read data matches the model.
  - Never two readys in one cycle.
  - mem_en high exactly once per access.
